// File: rtl/gray_counter.sv
// Gray-code up-counter with count enable and sticky wrap flag; one-edge latency, no combinational input-to-output path.
// No flow control: En gates each step, Reset overrides En, and when both are low all state holds.
module gray_counter #(
  parameter int WIDTH = 3
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             En,
  output logic [WIDTH-1:0] Output,
  output logic             Overflow
);

  // Initial values define the outputs before any reset (FPGA INIT / simulation).
  logic [WIDTH-1:0] bin      = '0;
  logic [WIDTH-1:0] gray_q   = '0;
  logic             ovf_q    = 1'b0;
  logic [WIDTH-1:0] bin_next;

  assign bin_next = bin + WIDTH'(1);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      bin    <= '0;
      gray_q <= '0;
      ovf_q  <= 1'b0;
    end else if (En) begin
      bin    <= bin_next;
      gray_q <= bin_next ^ (bin_next >> 1);
      // All-ones binary is the last Gray code; stepping from it is a wrap.
      if (&bin) ovf_q <= 1'b1;
    end
  end

  assign Output   = gray_q;
  assign Overflow = ovf_q;

endmodule

// File: tb/tb_gray_counter.sv
// Scoreboard bench for gray_counter at WIDTH=3 and WIDTH=4 using hand-written Gray tables.
module tb_gray_counter;

  typedef struct {
    logic       sel;     // 0: WIDTH=3 instance, 1: WIDTH=4 instance
    logic [3:0] out;
    logic       ovf;
    logic       onebit;  // expect exactly one bit changed from previous sample
    string      name;
  } exp_t;

  logic       Clk = 1'b0;
  logic       rst3 = 1'b0, en3 = 1'b1;
  logic       rst4 = 1'b0, en4 = 1'b0;
  logic [2:0] out3;
  logic [3:0] out4;
  logic       ovf3, ovf4;

  int checks = 0;
  int passed = 0;
  exp_t q[$];
  logic [3:0] prev3 = '0, prev4 = '0;

  logic [2:0] g3 [8]  = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};
  logic [3:0] g4 [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                          4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};

  gray_counter #(.WIDTH(3)) dut3 (.Clk(Clk), .Reset(rst3), .En(en3), .Output(out3), .Overflow(ovf3));
  gray_counter #(.WIDTH(4)) dut4 (.Clk(Clk), .Reset(rst4), .En(en4), .Output(out4), .Overflow(ovf4));

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %b, expected %b at %0t", name, act, req, $time);
  endtask

  task automatic push(input logic sel, input logic [3:0] out, input logic ovf,
                      input logic onebit, input string name);
    exp_t e;
    e.sel = sel; e.out = out; e.ovf = ovf; e.onebit = onebit; e.name = name;
    q.push_back(e);
  endtask

  // Drive inputs on the falling edge, then record the expectation for the next rising edge.
  task automatic step(input logic sel, input logic r, input logic e, input logic [3:0] out,
                      input logic ovf, input logic onebit, input string name);
    @(negedge Clk);
    if (sel) begin rst4 = r; en4 = e; rst3 = 1'b0; en3 = 1'b0; end
    else     begin rst3 = r; en3 = e; rst4 = 1'b0; en4 = 1'b0; end
    @(posedge Clk);
    #1 push(sel, out, ovf, onebit, name);
  endtask

  // Monitor: compare at every falling edge, away from the active edge.
  initial begin
    forever begin
      @(negedge Clk);
      while (q.size() > 0) begin
        exp_t e;
        logic [3:0] cur;
        logic       cur_ovf;
        e = q.pop_front();
        cur     = e.sel ? out4 : {1'b0, out3};
        cur_ovf = e.sel ? ovf4 : ovf3;
        check({e.name, "_out"}, cur, e.out);
        check({e.name, "_ovf"}, {3'b0, cur_ovf}, {3'b0, e.ovf});
        if (e.onebit)
          check({e.name, "_onebit"}, 4'($countones(cur ^ (e.sel ? prev4 : prev3))), 4'd1);
        if (e.sel) prev4 = cur; else prev3 = cur;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, queue depth %0d expected 0", q.size());
    $fatal(1, "timeout");
  end

  initial begin
    // Power-up values before any reset.
    #1;
    check("pwr_out3", {1'b0, out3}, 4'd0);
    check("pwr_ovf3", {3'b0, ovf3}, 4'd0);
    check("pwr_out4", out4, 4'd0);
    check("pwr_ovf4", {3'b0, ovf4}, 4'd0);

    // Counting from power-up with En already high: two full wraps.
    @(posedge Clk);
    #1 push(1'b0, {1'b0, g3[1]}, 1'b0, 1'b1, "pwr_cnt");
    for (int k = 2; k <= 16; k++)
      step(1'b0, 1'b0, 1'b1, {1'b0, g3[k % 8]}, (k >= 8), 1'b1, "pwr_cnt");

    // Reset held with En high: stays cleared.
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, "rst_hold");

    // Enable hold: three steps to 010, five idle edges, then 110.
    step(1'b0, 1'b0, 1'b1, 4'b0001, 1'b0, 1'b1, "en_a");
    step(1'b0, 1'b0, 1'b1, 4'b0011, 1'b0, 1'b1, "en_a");
    step(1'b0, 1'b0, 1'b1, 4'b0010, 1'b0, 1'b1, "en_a");
    for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 1'b0, 4'b0010, 1'b0, 1'b0, "en_hold");
    step(1'b0, 1'b0, 1'b1, 4'b0110, 1'b0, 1'b1, "en_resume");

    // Run round to 111 with Overflow set, then Reset and En together.
    step(1'b0, 1'b0, 1'b1, 4'b0111, 1'b0, 1'b1, "to111");
    step(1'b0, 1'b0, 1'b1, 4'b0101, 1'b0, 1'b1, "to111");
    step(1'b0, 1'b0, 1'b1, 4'b0100, 1'b0, 1'b1, "to111");
    step(1'b0, 1'b0, 1'b1, 4'b0000, 1'b1, 1'b1, "wrap3");
    step(1'b0, 1'b0, 1'b1, 4'b0001, 1'b1, 1'b1, "to111");
    step(1'b0, 1'b0, 1'b1, 4'b0011, 1'b1, 1'b1, "to111");
    step(1'b0, 1'b0, 1'b1, 4'b0010, 1'b1, 1'b1, "to111");
    step(1'b0, 1'b0, 1'b1, 4'b0110, 1'b1, 1'b1, "to111");
    step(1'b0, 1'b0, 1'b1, 4'b0111, 1'b1, 1'b1, "to111");
    step(1'b0, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, "rst_prio");

    // Twenty enabled edges, one-bit change each, including 100->000.
    for (int k = 1; k <= 20; k++)
      step(1'b0, 1'b0, 1'b1, {1'b0, g3[k % 8]}, (k >= 8), 1'b1, "run20");

    // WIDTH=4: reset then full 16-entry sequence; dut3 idles meanwhile.
    step(1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, "w4_rst");
    for (int k = 1; k <= 17; k++)
      step(1'b1, 1'b0, 1'b1, g4[k % 16], (k >= 16), 1'b1, "w4_cnt");

    @(negedge Clk);
    rst4 = 1'b0; en4 = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    check("idle3_out", {1'b0, out3}, {1'b0, g3[4]});
    check("idle3_ovf", {3'b0, ovf3}, 4'd1);
    check("queue_drained", 4'(q.size()), 4'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/gray_counter.md
Name: gray_counter

Overview:
- Synchronous Gray-code up-counter with a count enable and a sticky overflow flag.
- Default width is 3 bits, giving the sequence 000,001,011,010,110,111,101,100.
- Used as a small sequencing/state source, clocked by the system clock `Clk` and cleared by `Reset`.
- Internally holds a binary count; the output is the registered Gray encoding of that count.

Parameters:
- WIDTH, 3, counter and output width in bits (must be >= 2).

Ports:
- Clk  input  1  system clock; all state changes on its rising edge.
- Reset  input  1  synchronous, active-high reset; clears count and Overflow.
- En  input  1  count enable; when high the counter advances one Gray step per rising edge.
- Output  output  WIDTH  current Gray-coded count, registered.
- Overflow  output  1  sticky flag, set on first wrap from the last Gray code back to zero.

Behaviour:
- One clock, `Clk`. Reset is synchronous and active-high.
- All registers (binary count, Output, Overflow) have a power-up/initial value of 0 in simulation and on FPGA INIT. Outputs are therefore defined before any reset.
- Priority per rising edge of Clk: Reset > En > hold.
- Reset=1 at an edge: binary count = 0, Output = 0, Overflow = 0, regardless of En.
  - Reset applied mid-sequence or while Overflow=1 clears both on that edge.
- Reset=0, En=1:
  - bin_next = bin + 1, modulo 2^WIDTH.
  - Output <= bin_next ^ (bin_next >> 1).
  - Output changes in exactly one bit per step.
- Wrap-around: when bin = 2^WIDTH-1 (Output = 100 for WIDTH=3) and En=1, the next edge gives bin = 0, Output = 000, and Overflow = 1 on that same edge.
- Overflow is sticky. It remains 1 through further counting and further wraps until a Reset edge.
- Reset=0, En=0: bin, Output and Overflow all hold.
- Latency: Output reflects an enabled increment one edge after En is sampled high. There is no combinational path from inputs to outputs.
- Output and Overflow are driven directly from flops, so there are no glitches.
- WIDTH=3 sequence after reset with En held high, per edge:
  000 -> 001 -> 011 -> 010 -> 110 -> 111 -> 101 -> 100 -> 000 (Overflow=1) -> 001 ...

Test Plan:
- Power-up count: Reset=0, En=1, 10 ns clock from t=0. Output cycles 000,001,011,010,110,111,101,100. Overflow rises at the 8th edge, as Output returns to 000, and stays 1 on later wraps.
- Sync reset: at t=300 ns raise Reset and hold it. At the next rising edge Output=000 and Overflow=0. Both stay 0 while Reset=1 even with En=1. Nothing changes between edges.
- Enable hold: reset, then En=1 for 3 edges (Output=010). Set En=0 for 5 edges: Output stays 010 and Overflow stays 0. Re-enable: the next edge gives 110.
- Reset vs enable priority: Reset=1 and En=1 on the same edge while Output=111 and Overflow=1 -> Output=000, Overflow=0.
- Single-bit-change check: over 20 enabled edges, assert popcount(Output_prev ^ Output) == 1 on every edge, including 100->000.
- Parameter check: WIDTH=4, En=1 from reset. Output follows the 16-entry Gray sequence ending 1000. Overflow sets exactly on the 16th edge.
